// File: rtl/lc3_fetch.sv
`default_nettype none
// ============================================================================
// Module   : lc3_fetch
// Purpose  : LC-3 instruction-fetch unit. It captures the PC on a fetch
//            request and issues a single-beat read on the instruction-memory
//            req/ready handshake. A good word is latched into the IR, and
//            ir_valid/pc_inc pulse for one cycle when it is delivered.
//            A flush during the request phase discards the returned word.
// Option   : define LC3_FETCH_TIMEOUT_EN to abort a request that sees no
//            mem_ready for TIMEOUT_CYCLES cycles. The abort pulses fetch_err.
//            Without the macro, REQ waits forever and fetch_err is tied low.
// Ports    : clk, reset (sync, active-low)
//            pc[15:0], fetch_start, flush           <- control / PC
//            mem_req, mem_addr[15:0]                -> instruction memory
//            mem_ready, mem_rdata[15:0]             <- instruction memory
//            ir[15:0], ir_valid, pc_inc, busy, fetch_err -> core
// Revision : 1.0 - initial release
// ============================================================================
module lc3_fetch #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pc,
  input  logic        fetch_start,
  input  logic        flush,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  output logic [15:0] ir,
  output logic        ir_valid,
  output logic        pc_inc,
  output logic        busy,
  output logic        fetch_err
);

  localparam logic [15:0] c_reset_addr = 16'h3000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_mem_addr;
  logic [15:0] r_ir;
  logic        r_flush_lat;
  logic        w_drop;
  logic        w_expire;

  // A flush seen in this REQ cycle or in any earlier one poisons the word.
  assign w_drop = r_flush_lat | flush;

  // The timeout must be between 1 and 65535 cycles. A value of zero would
  // make the 16-bit compare below meaningless. This block is kept empty so
  // the parameter stays referenced in builds without the timeout.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_zero
  end

`ifdef LC3_FETCH_TIMEOUT_EN
  localparam logic [15:0] c_to_last = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_to_cnt;
  logic        r_fetch_err;

  // r_to_cnt holds the number of REQ cycles already completed. It is zero
  // in the first REQ cycle because it is held clear outside REQ. A ready in
  // the expiring cycle takes priority and completes the fetch.
  assign w_expire = (r_state == S_REQ) && !mem_ready && (r_to_cnt == c_to_last);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_to_cnt    <= 16'h0000;
      r_fetch_err <= 1'b0;
    end else begin
      r_fetch_err <= w_expire;
      if (r_state == S_REQ) begin
        r_to_cnt <= r_to_cnt + 16'h0001;
      end else begin
        r_to_cnt <= 16'h0000;
      end
    end
  end

  assign fetch_err = r_fetch_err;
`else
  assign w_expire  = 1'b0;
  assign fetch_err = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (fetch_start) begin
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ready) begin
          w_state_nxt = w_drop ? S_IDLE : S_DONE;
        end else if (w_expire) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath: address capture, IR load and flush latch
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mem_addr  <= c_reset_addr;
      r_ir        <= 16'h0000;
      r_flush_lat <= 1'b0;
    end else begin
      // The address is captured only when leaving IDLE, so it stays
      // frozen for the whole request.
      if ((r_state == S_IDLE) && fetch_start) begin
        r_mem_addr <= pc;
      end
      if ((r_state == S_REQ) && mem_ready && !w_drop) begin
        r_ir <= mem_rdata;
      end
      // The latch is remembered only while the request continues. Any exit
      // from REQ, or no REQ at all, leaves it clear.
      r_flush_lat <= (r_state == S_REQ) && (w_state_nxt == S_REQ) && w_drop;
    end
  end

  // All outputs come from registers or from a decode of the state register.
  assign mem_req  = (r_state == S_REQ);
  assign mem_addr = r_mem_addr;
  assign ir       = r_ir;
  assign ir_valid = (r_state == S_DONE);
  assign pc_inc   = (r_state == S_DONE);
  assign busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_lc3_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_lc3_fetch
// Purpose  : Self-checking bench for lc3_fetch. Directed scenarios are
//            followed by random per-cycle stimulus. A transaction-level
//            reference model predicts every output after each clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lc3_fetch;

  localparam int TO = 4;
`ifdef LC3_FETCH_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] pc = 16'h0000;
  logic        fetch_start = 1'b0;
  logic        flush = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ready = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic [15:0] ir;
  logic        ir_valid;
  logic        pc_inc;
  logic        busy;
  logic        fetch_err;

  always #5 clk = ~clk;

  lc3_fetch #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .fetch_start (fetch_start),
    .flush       (flush),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .ir          (ir),
    .ir_valid    (ir_valid),
    .pc_inc      (pc_inc),
    .busy        (busy),
    .fetch_err   (fetch_err)
  );

  int n_total = 0;
  int n_bad   = 0;
  int n_valid = 0;

  // Reference model: one outstanding fetch transaction
  bit          m_active;   // a read is outstanding on the memory port
  bit          m_deliver;  // the instruction is being handed over this cycle
  bit          m_err;      // the request was abandoned last cycle
  bit          m_flushed;  // the outstanding read has been poisoned
  int          m_wait;     // request cycles spent on the outstanding read
  logic [15:0] m_addr;
  logic [15:0] m_ir;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active  = 0;
    m_deliver = 0;
    m_err     = 0;
    m_flushed = 0;
    m_wait    = 0;
    m_addr    = 16'h3000;
    m_ir      = 16'h0000;
  endtask

  // Advance the transaction model by one clock using the inputs that were
  // presented before the edge.
  task automatic model_edge();
    bit nd;
    bit ne;
    bit poisoned;
    nd = 0;
    ne = 0;
    if (!reset) begin
      model_reset();
      return;
    end
    if (m_deliver) begin
      // The hand-over cycle ignores every input.
    end else if (!m_active) begin
      if (fetch_start) begin
        m_active  = 1;
        m_addr    = pc;
        m_wait    = 0;
        m_flushed = 0;
      end
    end else begin
      m_wait++;
      poisoned = m_flushed | flush;
      if (mem_ready) begin
        m_active  = 0;
        m_flushed = 0;
        if (!poisoned) begin
          m_ir = mem_rdata;
          nd   = 1;
        end
      end else if (TO_EN && m_wait == TO) begin
        m_active  = 0;
        m_flushed = 0;
        ne        = 1;
      end else begin
        m_flushed = poisoned;
      end
    end
    m_deliver = nd;
    m_err     = ne;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (ir_valid) n_valid++;
    chk("mem_req",   32'(mem_req),   32'(m_active));
    chk("mem_addr",  32'(mem_addr),  32'(m_addr));
    chk("ir",        32'(ir),        32'(m_ir));
    chk("ir_valid",  32'(ir_valid),  32'(m_deliver));
    chk("pc_inc",    32'(pc_inc),    32'(m_deliver));
    chk("busy",      32'(busy),      32'(m_active | m_deliver));
    chk("fetch_err", 32'(fetch_err), 32'(m_err));
  endtask

  task automatic idle_inputs();
    fetch_start = 0;
    flush       = 0;
    mem_ready   = 0;
  endtask

  initial begin
    int v0;
    model_reset();

    // Reset state
    reset = 0;
    step();
    step();
    chk("rst_addr", 32'(mem_addr), 32'h3000);
    chk("rst_ir",   32'(ir),       32'h0000);

    // Minimum-latency fetch
    reset = 1;
    step();
    v0 = n_valid;
    pc = 16'h3000; fetch_start = 1;
    step();
    chk("t1_req", 32'(mem_req), 32'h1);
    fetch_start = 0; mem_ready = 1; mem_rdata = 16'h1261;
    step();
    mem_ready = 0;
    chk("t1_valid", 32'(ir_valid), 32'h1);
    chk("t1_ir",    32'(ir),       32'h1261);
    step();
    chk("t1_busy",  32'(busy),     32'h0);
    chk("t1_count", 32'(n_valid - v0), 32'd1);

    // Delayed ready, with a fetch_start during REQ that must be ignored
    v0 = n_valid;
    pc = 16'h3100; fetch_start = 1;
    step();
    fetch_start = 0;
    for (int i = 0; i < 5; i++) begin
      fetch_start = (i == 2);
      pc = 16'h4444;
      step();
    end
    fetch_start = 0;
    chk("t2_addr", 32'(mem_addr), 32'h3100);
    mem_ready = 1; mem_rdata = 16'h0A0A;
    step();
    mem_ready = 0;
    step();
    step();
    chk("t2_ir",    32'(ir),           32'h0A0A);
    chk("t2_count", 32'(n_valid - v0), 32'd1);

    // Flush in 2nd REQ cycle, ready in 4th REQ cycle
    v0 = n_valid;
    pc = 16'h3200; fetch_start = 1;
    step();                          // now REQ cycle 1
    fetch_start = 0;
    step();                          // now REQ cycle 2
    flush = 1;
    step();                          // now REQ cycle 3
    flush = 0;
    step();                          // now REQ cycle 4
    mem_ready = 1; mem_rdata = 16'hBEEF;
    step();
    mem_ready = 0;
    chk("t3_busy",  32'(busy),         32'h0);
    chk("t3_ir",    32'(ir),           32'h0A0A);
    step();
    chk("t3_count", 32'(n_valid - v0), 32'd0);

    // Reset during REQ, then a normal fetch
    v0 = n_valid;
    pc = 16'h3300; fetch_start = 1;
    step();
    fetch_start = 0;
    reset = 0;
    step();
    chk("t4_req",  32'(mem_req),  32'h0);
    chk("t4_addr", 32'(mem_addr), 32'h3000);
    chk("t4_ir",   32'(ir),       32'h0000);
    reset = 1;
    pc = 16'h3005; fetch_start = 1;
    step();
    chk("t4_addr2", 32'(mem_addr), 32'h3005);
    fetch_start = 0; mem_ready = 1; mem_rdata = 16'h5A5A;
    step();
    mem_ready = 0;
    chk("t4_valid", 32'(ir_valid), 32'h1);
    chk("t4_ir2",   32'(ir),       32'h5A5A);
    step();
    chk("t4_count", 32'(n_valid - v0), 32'd1);

    // Timeout behaviour, or an indefinite wait when it is not built in
    if (TO_EN) begin
      pc = 16'h3400; fetch_start = 1;
      step();                        // REQ cycle 1
      fetch_start = 0;
      step(); step(); step();        // REQ cycles 2..4
      chk("t5_req4", 32'(mem_req), 32'h1);
      step();
      chk("t5_drop", 32'(mem_req),   32'h0);
      chk("t5_err",  32'(fetch_err), 32'h1);
      step();
      chk("t5_err1", 32'(fetch_err), 32'h0);
      v0 = n_valid;
      pc = 16'h3401; fetch_start = 1;
      step();
      fetch_start = 0;
      step(); step(); step();
      mem_ready = 1; mem_rdata = 16'h7777;
      step();
      mem_ready = 0;
      chk("t5_valid", 32'(ir_valid),  32'h1);
      chk("t5_noerr", 32'(fetch_err), 32'h0);
      chk("t5_ir",    32'(ir),        32'h7777);
      step();
    end else begin
      pc = 16'h3400; fetch_start = 1;
      step();
      fetch_start = 0;
      for (int i = 0; i < 10; i++) step();
      chk("t5_wait", 32'(mem_req),   32'h1);
      chk("t5_err",  32'(fetch_err), 32'h0);
      mem_ready = 1; mem_rdata = 16'h7777;
      step();
      mem_ready = 0;
      chk("t5_ir", 32'(ir), 32'h7777);
      step();
    end

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 59) != 0);
      fetch_start = ($urandom_range(0, 1) == 1);
      flush       = ($urandom_range(0, 6) == 0);
      mem_ready   = ($urandom_range(0, 9) < 3);
      pc          = 16'($urandom);
      mem_rdata   = 16'($urandom);
      step();
    end
    idle_inputs();
    reset = 1;
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/lc3_fetch.md
# lc3_fetch

Instruction-fetch unit for the LC-3 core. It consumes the program counter, issues a single-beat read on the instruction-memory request/ready handshake and latches the returned word into the instruction register. When an instruction is delivered it pulses `pc_inc` so the program counter advances. It sits between the PC register, the control FSM and the instruction memory port.

## Interface
- `TIMEOUT_CYCLES`, 64: REQ-state cycles without `mem_ready` before abort (used only when timeout is compiled in); legal range 1..65535.
- `clk` in 1: single clock; all state changes on rising edge.
- `reset` in 1: synchronous, active-low; sampled on rising edge of `clk`.
- `pc` in 16: current program counter.
- `fetch_start` in 1: control requests one fetch; honoured only in IDLE.
- `flush` in 1: discard the in-flight fetch (branch/redirect).
- `mem_req` out 1: read request to instruction memory.
- `mem_addr` out 16: read address; stable while `mem_req`=1.
- `mem_ready` in 1: memory accepts the request and returns `mem_rdata` in the same cycle.
- `mem_rdata` in 16: instruction word; valid only when `mem_ready`=1 and `mem_req`=1.
- `ir` out 16: instruction register.
- `ir_valid` out 1: one-cycle pulse; `ir` holds a newly fetched word.
- `pc_inc` out 1: one-cycle pulse, coincident with `ir_valid`; PC advances.
- `busy` out 1: high in any state other than IDLE.
- `fetch_err` out 1: one-cycle pulse on timeout abort.

## Operation
- States: IDLE, REQ, DONE.
- IDLE: on `fetch_start`=1, latch `pc` into `mem_addr` and go to REQ. Otherwise stay.
- REQ: `mem_req`=1 and `mem_addr` held constant. On `mem_ready`=1:
  - if neither `flush` nor a latched flush is set: `ir` <= `mem_rdata`, go to DONE.
  - otherwise: the word is dropped, `ir` is unchanged, the flush latch clears, and the FSM goes to IDLE.
- Flush latch: set by `flush`=1 in any REQ cycle; cleared on leaving REQ.
- Once asserted, `mem_req` is never withdrawn before `mem_ready`, except on timeout.
- DONE: `ir_valid`=1 and `pc_inc`=1 for exactly this cycle, then IDLE. `flush` in DONE has no effect.
- `fetch_start` outside IDLE is ignored; it is not queued.
- `flush` in IDLE is ignored.
- `mem_ready` outside REQ is ignored.
- All outputs are registered or decoded from the state register only; no input-to-output combinational paths.
- Reset values:
  - state IDLE; `mem_req` 0; `mem_addr` 16'h3000; `ir` 16'h0000.
  - `ir_valid` 0; `pc_inc` 0; `busy` 0; `fetch_err` 0.
  - flush latch 0; timeout counter 0.
- Reset asserted mid-fetch returns to IDLE on that edge with the reset values above. The in-flight word is lost, and no `ir_valid` or `pc_inc` is produced.

## Timing
- Cycle 0: `fetch_start`=1 in IDLE.
- Cycle 1: `mem_req`=1, `busy`=1.
- Cycle k (k≥1): first cycle with `mem_ready`=1.
- Cycle k+1: DONE; `ir_valid`=`pc_inc`=1 and the new `ir` is visible.
- Cycle k+2: IDLE; `busy`=0.
- Minimum fetch latency is 2 cycles from `fetch_start` to `ir_valid`.
- Back-to-back throughput is 1 instruction per 3 cycles. `fetch_start` may be asserted in the DONE cycle only if it is held into IDLE.
- `ir` holds its value until the next successful fetch.

## Configuration
- `LC3_FETCH_TIMEOUT_EN` defined:
  - a 16-bit counter counts REQ cycles and clears on REQ entry.
  - when it reaches `TIMEOUT_CYCLES` with `mem_ready`=0, the block drops `mem_req` and pulses `fetch_err` for 1 cycle (the first IDLE cycle).
  - `ir` is unchanged, and no `ir_valid` or `pc_inc` is produced.
  - `mem_ready` in the same cycle as expiry wins: the fetch completes normally.
- Not defined: REQ waits indefinitely, `fetch_err` is tied to 0, and no counter is synthesized.

## Test plan
- Reset, then `pc`=16'h3000 and `fetch_start` pulse, with `mem_ready` returned the next cycle carrying 16'h1261: `mem_addr`=16'h3000 and `mem_req` high for 1 cycle; `ir`=16'h1261; `ir_valid`/`pc_inc` high exactly in cycle 2.
- `mem_ready` delayed 5 cycles: `mem_req` and `mem_addr` are stable throughout; a `fetch_start` pulse during REQ is ignored; exactly one `ir_valid` is produced.
- `flush` pulsed in the 2nd REQ cycle, `mem_ready` in the 4th REQ cycle with 16'hBEEF: `ir` keeps its prior value; no `ir_valid` or `pc_inc`; `busy` drops the next cycle.
- Active-low `reset` asserted during REQ: on the next edge all outputs take their reset values, and a later fetch from `pc`=16'h3005 behaves normally.
- With `LC3_FETCH_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, `mem_ready` held 0: `mem_req` drops after 4 REQ cycles and `fetch_err` pulses once. A repeat run with `mem_ready`=1 exactly on the 4th cycle delivers the instruction with no `fetch_err`.
